// File: rtl/my_reduce_n_way_pipe_pkg.sv
// Shared types and elaboration-time helpers for the pipelined N-way reducer.
// Tree geometry (levels, partials per level, flat offsets) is derived here.
package my_reduce_pkg;

  typedef enum logic [1:0] {
    OP_OR  = 2'b00,
    OP_AND = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  // Value that leaves a reduction unchanged; used to fill unused node inputs.
  function automatic logic identity(op_t op);
    return (op == OP_AND);
  endfunction

  // Partials present at a tree level; level 0 is the raw input word.
  function automatic int node_width(int width, int leaf, int level);
    int w;
    w = width;
    for (int i = 0; i < level; i++) begin
      w = (w + leaf - 1) / leaf;
    end
    return w;
  endfunction

  // Tree depth, which is also the pipeline latency.
  function automatic int clog_leaf(int width, int leaf);
    int w;
    int s;
    w = width;
    s = 0;
    while (w > 1) begin
      w = (w + leaf - 1) / leaf;
      s++;
    end
    return (s < 1) ? 1 : s;
  endfunction

  // Bit offset of a level's partials inside the flattened stage register.
  function automatic int level_offset(int width, int leaf, int level);
    int off;
    off = 0;
    for (int k = 1; k < level; k++) begin
      off += node_width(width, leaf, k);
    end
    return off;
  endfunction

endpackage

// File: rtl/my_reduce_n_way_pipe_if.sv
// Upstream word / downstream result bus for my_reduce_n_way_pipe.
// Both sides use valid/ready: a transfer happens on a rising edge where valid
// and ready are both high; valid and its payload hold until that transfer.
interface my_reduce_n_way_pipe_if #(
  parameter int WIDTH = 8
);
  import my_reduce_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  op_t              in_op;
  logic             out_valid;
  logic             out_ready;
  logic             out_bit;
  op_t              out_op;

  modport master (
    output in_valid, in_data, in_op, out_ready,
    input  in_ready, out_valid, out_bit, out_op
  );

  modport slave (
    input  in_valid, in_data, in_op, out_ready,
    output in_ready, out_valid, out_bit, out_op
  );

endinterface

// File: rtl/my_reduce_n_way_pipe_node.sv
// One combinational tree node: reduces LEAF bits with the word's operation.
// NOR reduces as OR here; the inversion happens once at the tree root.
module my_reduce_node
  import my_reduce_pkg::*;
#(
  parameter int LEAF = 4
) (
  input  logic [LEAF-1:0] in_bits,
  input  op_t             op,
  output logic            out_bit
);

  always_comb begin
    out_bit = |in_bits;
    case (op)
      OP_AND:  out_bit = &in_bits;
      OP_XOR:  out_bit = ^in_bits;
      default: out_bit = |in_bits;
    endcase
  end

endmodule

// File: rtl/my_reduce_n_way_pipe.sv
// Pipelined OR/AND/XOR/NOR reducer: a LEAF-ary tree with one register per level.
// Optional sticky accumulator of consumed results under MY_REDUCE_STICKY_EN.
module my_reduce_n_way_pipe
  import my_reduce_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEAF  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  my_reduce_n_way_pipe_if.slave bus
`ifdef MY_REDUCE_STICKY_EN
  ,
  input  logic                  sticky_clr,
  output logic                  sticky_bit
`endif
);

  localparam int STAGES = clog_leaf(WIDTH, LEAF);
  localparam int TOTAL  = level_offset(WIDTH, LEAF, STAGES + 1);

  logic              advance;
  logic              accept;
  logic [STAGES-1:0] valid_q;
  op_t               op_q [STAGES];
  logic [TOTAL-1:0]  data_q;
  logic [TOTAL-1:0]  data_d;
  logic [TOTAL-1:0]  ld_mask;

  // Global enable: the whole pipe moves only when the output slot is free
  // or being drained this cycle, so bubbles hold along with real words.
  assign advance = !valid_q[STAGES-1] || bus.out_ready;
  assign accept  = bus.in_valid && advance;

  for (genvar l = 1; l <= STAGES; l++) begin : g_level
    localparam int PW  = node_width(WIDTH, LEAF, l - 1);
    localparam int NW  = node_width(WIDTH, LEAF, l);
    localparam int OFF = level_offset(WIDTH, LEAF, l);

    logic [PW-1:0]      src;
    op_t                lvl_op;
    logic [NW*LEAF-1:0] padded;
    logic [NW-1:0]      node_out;

    if (l == 1) begin : g_first
      assign src    = bus.in_data;
      assign lvl_op = bus.in_op;
    end else begin : g_inner
      assign src    = data_q[level_offset(WIDTH, LEAF, l - 1) +: PW];
      assign lvl_op = op_q[l-2];
    end

    for (genvar i = 0; i < NW * LEAF; i++) begin : g_pad
      if (i < PW) begin : g_src
        assign padded[i] = src[i];
      end else begin : g_ident
        assign padded[i] = identity(lvl_op);
      end
    end

    for (genvar n = 0; n < NW; n++) begin : g_node
      my_reduce_node #(
        .LEAF(LEAF)
      ) u_node (
        .in_bits(padded[n*LEAF +: LEAF]),
        .op     (lvl_op),
        .out_bit(node_out[n])
      );
    end

    if (l == STAGES) begin : g_root
      assign data_d[OFF +: NW] = node_out ^ {NW{lvl_op == OP_NOR}};
    end else begin : g_mid
      assign data_d[OFF +: NW] = node_out;
    end

    // Level 1 loads only on accept so an idle (possibly unknown) input never
    // reaches the registers; deeper levels follow the global enable.
    if (l == 1) begin : g_ld_first
      assign ld_mask[OFF +: NW] = {NW{accept}};
    end else begin : g_ld_inner
      assign ld_mask[OFF +: NW] = {NW{advance}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        op_q[s] <= OP_OR;
      end
    end else begin
      data_q <= (data_q & ~ld_mask) | (data_d & ld_mask);
      if (accept) begin
        op_q[0] <= bus.in_op;
      end
      if (advance) begin
        valid_q[0] <= accept;
        for (int s = 1; s < STAGES; s++) begin
          valid_q[s] <= valid_q[s-1];
          op_q[s]    <= op_q[s-1];
        end
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = valid_q[STAGES-1];
  assign bus.out_bit   = data_q[TOTAL-1];
  assign bus.out_op    = op_q[STAGES-1];

`ifdef MY_REDUCE_STICKY_EN
  // Clear wins over a same-cycle output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_bit <= 1'b0;
    end else if (sticky_clr) begin
      sticky_bit <= 1'b0;
    end else if (valid_q[STAGES-1] && bus.out_ready) begin
      sticky_bit <= sticky_bit | data_q[TOTAL-1];
    end
  end
`endif

endmodule
